// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control types: redirect FSM encoding and default widths.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    REDIR_IDLE,
    REDIR_REQ,
    REDIR_FLUSH
  } redir_state_t;

  localparam int unsigned ADDR_W_DEFAULT = 32;

endpackage : pipeline_ctrl_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter

// File: rtl/branch_redirect_unit.sv
// Turns the execute-stage branch decision into a held fetch redirect plus a
// fixed-length Decode/Execute flush, and counts accepted and dropped redirects.
module branch_redirect_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              BranchTakenE,
  input  logic              PCSrcECU,
  input  logic [ADDR_W-1:0] BranchTargetE,
  input  logic [ADDR_W-1:0] ALUResultE,
  input  logic              InstrReadyF,
  output logic              PCRedirectF,
  output logic [ADDR_W-1:0] PCTargetF,
  output logic              StallF,
  output logic              FlushD,
  output logic              FlushE,
  output logic              Busy,
  output logic [CNT_W-1:0]  RedirectCount,
  output logic [CNT_W-1:0]  DroppedCount
);

  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  redir_state_t      state_q, state_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic              redirect_inc;
  logic              dropped_inc;
  logic              ev;

  assign ev = BranchTakenE | PCSrcECU;

  // State, latched target and flush down-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= REDIR_IDLE;
      target_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state logic; events arriving outside IDLE are counted as dropped.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    flush_cnt_d  = flush_cnt_q;
    redirect_inc = 1'b0;
    dropped_inc  = 1'b0;
    unique case (state_q)
      REDIR_IDLE: begin
        if (ev) begin
          target_d = PCSrcECU ? ALUResultE : BranchTargetE;
          state_d  = REDIR_REQ;
        end
      end
      REDIR_REQ: begin
        dropped_inc = ev;
        if (InstrReadyF) begin
          redirect_inc = 1'b1;
          if (FLUSH_CYCLES == 1) begin
            state_d = REDIR_IDLE;
          end else begin
            state_d     = REDIR_FLUSH;
            flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
          end
        end
      end
      REDIR_FLUSH: begin
        dropped_inc = ev;
        flush_cnt_d = flush_cnt_q - FC_W'(1);
        if (flush_cnt_q <= FC_W'(1)) begin
          state_d = REDIR_IDLE;
        end
      end
      default: begin
        state_d = REDIR_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; StallF is the only input-dependent output.
  always_comb begin
    PCRedirectF = (state_q == REDIR_REQ);
    StallF      = (state_q == REDIR_REQ) && !InstrReadyF;
    FlushD      = (state_q != REDIR_IDLE);
    FlushE      = (state_q != REDIR_IDLE);
    Busy        = (state_q != REDIR_IDLE);
    PCTargetF   = target_q;
  end

  sat_counter #(
    .W (CNT_W)
  ) u_redirect_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (redirect_inc),
    .count (RedirectCount)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_dropped_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (dropped_inc),
    .count (DroppedCount)
  );

endmodule : branch_redirect_unit
